// File: rtl/spi_arb_pkg.sv
// Shared types and default parameter values for the SPI master arbiter.
// - state_e: arbiter sequencing states (idle, start pulse, wait for done, response)
// - *_DEFAULT constants: default NUM_REQ, DATA_W and TIMEOUT_CYC
package spi_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT     = 4;
  localparam int unsigned DATA_W_DEFAULT      = 8;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req   in  NUM_REQ           request vector
//   ptr   in  $clog2(NUM_REQ)   highest-priority index for this pick
//   grant out NUM_REQ           one-hot winner (first set req bit from ptr upward, wrapping)
//   any   out 1                 at least one request is pending
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       any
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters.
// Sequence per transfer: grant + latch TX word, pulse spi_start, wait for spi_done,
// pulse rsp_valid to the winner with the received word.
// Optional feature macro: SPI_ARB_TIMEOUT_EN (WAIT watchdog of TIMEOUT_CYC cycles;
// on expiry the response carries all-ones data and rsp_err = 1).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_data            per-requester request level and TX word
//   gnt, rsp_valid           one-hot grant, one-cycle response pulse
//   rsp_data, rsp_err        received word, timeout flag (qualified by rsp_valid)
//   busy                     high outside IDLE
//   spi_start, spi_data_in   to spi_master start / data_in
//   spi_data_out, spi_done   from spi_master data_out / done
//   spi_cs, cs_n             master chip select in, per-slave active-low selects out
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_data_in,
  input  logic [DATA_W-1:0]         spi_data_out,
  input  logic                      spi_done,
  input  logic                      spi_cs,
  output logic [NUM_REQ-1:0]        cs_n
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("spi_master_arbiter: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_in_q, data_in_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic [DATA_W-1:0]  arb_data;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_next;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (req),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .any  (arb_any)
  );

  // TX word of the arbitration winner.
  always_comb begin
    arb_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Index of the current grant holder; ptr moves just past it.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) win_idx = PTR_W'(i);
    end
  end

  assign ptr_next = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    data_in_d  = data_in_q;
    rsp_data_d = rsp_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A master still holding done from the last transfer blocks arbitration.
        if (arb_any && !spi_done) begin
          gnt_d     = arb_grant;
          data_in_d = arb_data;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (spi_done) begin
          rsp_data_d = spi_data_out;
`ifdef SPI_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = ST_RESP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        ptr_d   = ptr_next;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      data_in_q  <= '0;
      rsp_data_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      data_in_q  <= data_in_d;
      rsp_data_q <= rsp_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = (state_q == ST_RESP) ? gnt_q : '0;
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign spi_start   = (state_q == ST_START);
  assign spi_data_in = data_in_q;
  assign cs_n        = ~(gnt_q & {NUM_REQ{~spi_cs}});

`ifdef SPI_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    logic       err;
    logic [7:0] tx;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] sb;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out;
  logic        spi_done;
  logic        spi_cs;
  logic [3:0]  cs_n;

  int   total = 0;
  int   bad = 0;
  int   rsp_count = 0;
  int   starts = 0;
  int   xfer_len = 4;
  int   done_hold = 1;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_arr [4];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] cs_exp;
  vec_t vecs [6];

  spi_master_arbiter #(
    .NUM_REQ    (4),
    .DATA_W     (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .spi_start   (spi_start),
    .spi_data_in (spi_data_in),
    .spi_data_out(spi_data_out),
    .spi_done    (spi_done),
    .spi_cs      (spi_cs),
    .cs_n        (cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [7:0] tx_of(input logic [3:0] g);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 4; i++) if (g[i]) t = tx_arr[i];
    return t;
  endfunction

  task automatic push_exp(input logic [3:0] g, input logic [7:0] d, input logic e);
    exp_t x;
    x.gnt  = g;
    x.data = d;
    x.err  = e;
    x.tx   = tx_of(g);
    exp_q.push_back(x);
  endtask

  task automatic wait_rsps(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_arrival", 32'(rsp_count >= target), 32'd1);
  endtask

  // Single transfer starting from IDLE; also checks grant/start latency.
  task automatic xfer_one(input logic [3:0] r, input logic [3:0] g, input logic [7:0] sb,
                          input string nm);
    int tgt;
    slave_byte = sb;
    push_exp(g, sb, 1'b0);
    tgt = rsp_count + 1;
    req = r;
    @(negedge clk);
    check({nm, "_gnt"}, 32'(gnt), 32'(g));
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_start"}, 32'(spi_start), 32'd1);
    wait_rsps(tgt, 80);
    req = '0;
    @(negedge clk);
    #1;
  endtask

  // Hold a request mask until n responses arrive (expectations pushed by caller).
  task automatic run_held(input logic [3:0] r, input int n, input logic [7:0] sb);
    int tgt;
    slave_byte = sb;
    tgt = rsp_count + n;
    req = r;
    wait_rsps(tgt, 200);
    req = '0;
    @(negedge clk);
    #1;
  endtask

  // Behavioural spi_master/slave: latches data_in on start, completes after xfer_len cycles.
  initial begin
    spi_done     = 1'b0;
    spi_cs       = 1'b1;
    spi_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        rx_byte = spi_data_in;
        #1 spi_cs = 1'b0;
        repeat (xfer_len) @(negedge clk);
        #1;
        spi_data_out = slave_byte;
        spi_done     = 1'b1;
        spi_cs       = 1'b1;
        repeat (done_hold) @(negedge clk);
        #1 spi_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      starts = 0;
    end else begin
      if (spi_start) begin
        starts++;
        check("start_while_done", 32'(spi_done), 32'd0);
      end
      if (!spi_cs && exp_q.size() != 0) begin
        cs_exp = ~exp_q[0].gnt;
        check("cs_n", 32'(cs_n), 32'(cs_exp));
      end
      if (rsp_valid != 4'b0000) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, expected none", rsp_valid);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(mon_e.gnt));
          check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          check("slave_rx", 32'(rx_byte), 32'(mon_e.tx));
          check("starts_per_xfer", 32'(starts), 32'd1);
          starts = 0;
        end
      end
    end
  end

  initial begin
    int k;
    int tgt;
    tx_arr[0] = 8'h1E;
    tx_arr[1] = 8'hA5;
    tx_arr[2] = 8'hC3;
    tx_arr[3] = 8'hD4;
    req_data  = {tx_arr[3], tx_arr[2], tx_arr[1], tx_arr[0]};
    // req, expected grant, slave reply; ptr walks 0->2->1->0->2->1->3
    vecs[0] = '{req: 4'b0010, gnt: 4'b0010, sb: 8'h3C};
    vecs[1] = '{req: 4'b0001, gnt: 4'b0001, sb: 8'h5E};
    vecs[2] = '{req: 4'b1001, gnt: 4'b1000, sb: 8'h77};
    vecs[3] = '{req: 4'b0110, gnt: 4'b0010, sb: 8'h81};
    vecs[4] = '{req: 4'b0011, gnt: 4'b0001, sb: 8'h9C};
    vecs[5] = '{req: 4'b1100, gnt: 4'b0100, sb: 8'hE2};

    rst = 1'b1;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_data_in", 32'(spi_data_in), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'hF);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      xfer_one(vecs[i].req, vecs[i].gnt, vecs[i].sb, $sformatf("vec%0d", i));
    end

    // Fairness: ptr is 3 here, both 3 and 0 pending.
    push_exp(4'b1000, 8'h42, 1'b0);
    push_exp(4'b0001, 8'h42, 1'b0);
    run_held(4'b1001, 2, 8'h42);

    // Bring ptr to 0, then full round robin.
    xfer_one(4'b1000, 4'b1000, 8'h11, "pre_rr");
    push_exp(4'b0001, 8'h66, 1'b0);
    push_exp(4'b0010, 8'h66, 1'b0);
    push_exp(4'b0100, 8'h66, 1'b0);
    push_exp(4'b1000, 8'h66, 1'b0);
    push_exp(4'b0001, 8'h66, 1'b0);
    run_held(4'b1111, 5, 8'h66);

    // Held done: master keeps done high 5 extra cycles while req is pending.
    done_hold = 6;
    push_exp(4'b0100, 8'h99, 1'b0);
    push_exp(4'b0001, 8'h99, 1'b0);
    run_held(4'b0101, 2, 8'h99);
    repeat (8) @(negedge clk);
    #1 done_hold = 1;

    // Reset in WAIT: no response for the aborted transfer.
    xfer_len = 12;
    req = 4'b0100;
    @(negedge clk);
    check("rstmid_start", 32'(spi_start), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check("rstmid_gnt", 32'(gnt), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cs_n", 32'(cs_n), 32'hF);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    #1 xfer_len = 4;

    // ptr must be back at 0 after reset.
    xfer_one(4'b1111, 4'b0001, 8'hC7, "post_rst");

`ifdef SPI_ARB_TIMEOUT_EN
    xfer_len = 40;
    push_exp(4'b0001, 8'hFF, 1'b1);
    tgt = rsp_count + 1;
    req = 4'b0001;
    @(negedge clk);
    check("tmo_start", 32'(spi_start), 32'd1);
    k = 0;
    while (rsp_count < tgt && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("tmo_latency", 32'(k), 32'd17);
    req = 4'b0000;
    repeat (50) @(negedge clk);
    #1 xfer_len = 4;
`else
    k = 0;
    tgt = 0;
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
